fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory address.
- Collects the 32-bit word the memory returns one clock later and delivers it, with its PC, to decode over a valid/ready handshake.
- Handles decode backpressure with a one-entry skid buffer, and handles branch/jump redirects by flushing in-flight fetches.

---
 rtl/fetch_if.sv | 40 ++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory address/data, redirect input and the
// fetched-instruction output toward decode.
interface fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    // out_valid/out_ready: a transfer happens on a rising edge where both are 1;
    // once out_valid rises, out_instr/out_pc stay stable until that transfer
    // or a redirect, and out_ready never depends combinationally on out_valid.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle memory read stage, skid buffer and output register.
// Optional FETCH_PERF_EN adds transfer and stall counters.
module fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [ADDR_W-1:0] pc;
    logic              f1_valid;
    logic [ADDR_W-1:0] f1_pc;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_instr_r;
    logic [ADDR_W-1:0] out_pc_r;

    logic issue;
    logic load;

    // Stop issuing when the in-flight word would have nowhere to land next cycle.
    assign issue = !bus.redirect_valid && !skid_valid &&
                   !(f1_valid && out_valid_r && !bus.out_ready);
    assign load  = !out_valid_r || bus.out_ready;

    assign bus.imem_addr = pc;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_pc    = out_pc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            f1_valid    <= 1'b0;
            f1_pc       <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            out_valid_r <= 1'b0;
            out_instr_r <= '0;
            out_pc_r    <= '0;
        end else if (bus.redirect_valid) begin
            pc          <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            f1_valid    <= 1'b0;
            skid_valid  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (issue) begin
                f1_valid <= 1'b1;
                f1_pc    <= pc;
                pc       <= pc + ADDR_W'(4);
            end else begin
                f1_valid <= 1'b0;
            end

            if (load) begin
                if (skid_valid) begin
                    out_instr_r <= skid_instr;
                    out_pc_r    <= skid_pc;
                    out_valid_r <= 1'b1;
                    if (f1_valid) begin
                        skid_instr <= bus.imem_data;
                        skid_pc    <= f1_pc;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (f1_valid) begin
                    out_instr_r <= bus.imem_data;
                    out_pc_r    <= f1_pc;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (f1_valid) begin
                // Output is stalled: park the returning word so it is not lost.
                skid_instr <= bus.imem_data;
                skid_pc    <= f1_pc;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid_r && !bus.out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous memory model where word[i] = 0x1000_0000 + i.
module tb_fetch_unit;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    logic [ADDR_W-1:0] got_pc[$];

    fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        bus.imem_data <= 32'h1000_0000 + 32'(bus.imem_addr >> 2);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle after release).
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        got_pc.delete();
        for (int c = 0; c < budget && got_pc.size() < n; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (bus.out_instr !== 32'h1000_0000 + 32'(bus.out_pc >> 2)) begin
                    mismatched++;
                    $display("FAIL collect_instr pc=%h got=%h want=%h", bus.out_pc,
                             bus.out_instr, 32'h1000_0000 + 32'(bus.out_pc >> 2));
                end
                got_pc.push_back(bus.out_pc);
            end
            step();
        end
        compared++;
        if (got_pc.size() != n) begin
            mismatched++;
            $display("FAIL collect_timeout got=%0d want=%0d", got_pc.size(), n);
        end
    endtask

    task automatic check_seq(input string name, input logic [ADDR_W-1:0] e0,
                             input logic [ADDR_W-1:0] e1, input logic [ADDR_W-1:0] e2);
        logic [ADDR_W-1:0] exp_q[$];
        exp_q = '{e0, e1, e2};
        for (int k = 0; k < 3 && k < got_pc.size(); k++) begin
            compared++;
            if (got_pc[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL %s[%0d] got=%h want=%h", name, k, got_pc[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        compared += 4;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        if (bus.out_pc !== 8'h00) begin mismatched++; $display("FAIL rst_pc got=%h want=00", bus.out_pc); end
        if (bus.out_instr !== 32'h0) begin mismatched++; $display("FAIL rst_instr got=%h want=0", bus.out_instr); end
        if (bus.imem_addr !== 8'h00) begin mismatched++; $display("FAIL rst_addr got=%h want=00", bus.imem_addr); end
        rst_n = 1'b1;
        step();
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL c1_valid got=%b want=0", bus.out_valid); end
        if (bus.imem_addr !== 8'h04) begin mismatched++; $display("FAIL c1_addr got=%h want=04", bus.imem_addr); end
        step();
        compared += 3;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL c2_valid got=%b want=1", bus.out_valid); end
        if (bus.out_pc !== 8'h00) begin mismatched++; $display("FAIL c2_pc got=%h want=00", bus.out_pc); end
        if (bus.out_instr !== 32'h1000_0000) begin mismatched++; $display("FAIL c2_instr got=%h want=10000000", bus.out_instr); end
    endtask

    // Continues from cycle 2 of test_reset: one instruction per clock.
    task automatic test_stream();
        logic [ADDR_W-1:0] epc;
        for (int i = 1; i <= 5; i++) begin
            step();
            epc = 8'(4 * i);
            compared += 3;
            if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d] got=%b want=1", i, bus.out_valid); end
            if (bus.out_pc !== epc) begin mismatched++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, bus.out_pc, epc); end
            if (bus.out_instr !== 32'h1000_0000 + 32'(i)) begin
                mismatched++;
                $display("FAIL stream_instr[%0d] got=%h want=%h", i, bus.out_instr, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (4) step();
        compared++;
        if (bus.out_pc !== 8'h08) begin mismatched++; $display("FAIL bp_start got=%h want=08", bus.out_pc); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            compared += 4;
            if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d] got=%b want=1", i, bus.out_valid); end
            if (bus.out_pc !== 8'h08) begin mismatched++; $display("FAIL bp_pc[%0d] got=%h want=08", i, bus.out_pc); end
            if (bus.out_instr !== 32'h1000_0002) begin mismatched++; $display("FAIL bp_instr[%0d] got=%h want=10000002", i, bus.out_instr); end
            if (bus.imem_addr > 8'h14) begin mismatched++; $display("FAIL bp_addr[%0d] got=%h want<=14", i, bus.imem_addr); end
        end
        bus.out_ready = 1'b1;
        collect(3, 20);
        check_seq("bp_seq", 8'h08, 8'h0C, 8'h10);
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h42;
        step();
        bus.redirect_valid = 1'b0;
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL redir_r1 got=%b want=0", bus.out_valid); end
        if (bus.imem_addr !== 8'h40) begin mismatched++; $display("FAIL redir_addr got=%h want=40", bus.imem_addr); end
        step();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL redir_r2 got=%b want=0", bus.out_valid); end
        step();
        compared += 3;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL redir_r3_valid got=%b want=1", bus.out_valid); end
        if (bus.out_pc !== 8'h40) begin mismatched++; $display("FAIL redir_r3_pc got=%h want=40", bus.out_pc); end
        if (bus.out_instr !== 32'h1000_0010) begin mismatched++; $display("FAIL redir_r3_instr got=%h want=10000010", bus.out_instr); end
        step();
        compared++;
        if (bus.out_pc !== 8'h44) begin mismatched++; $display("FAIL redir_r4_pc got=%h want=44", bus.out_pc); end
    endtask

    task automatic test_redirect_stalled();
        do_reset();
        repeat (2) step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        compared++;
        if (bus.out_pc !== 8'h00) begin mismatched++; $display("FAIL rs_held got=%h want=00", bus.out_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h80;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rs_r1 got=%b want=0", bus.out_valid); end
        step();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rs_r2 got=%b want=0", bus.out_valid); end
        step();
        compared += 2;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL rs_r3_valid got=%b want=1", bus.out_valid); end
        if (bus.out_pc !== 8'h80) begin mismatched++; $display("FAIL rs_r3_pc got=%h want=80", bus.out_pc); end
        collect(3, 10);
        check_seq("rs_seq", 8'h80, 8'h84, 8'h88);
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'hF8;
        step();
        bus.redirect_valid = 1'b0;
        collect(4, 12);
        check_seq("wrap_seq", 8'hF8, 8'hFC, 8'h00);
        compared++;
        if (got_pc.size() < 4 || got_pc[3] !== 8'h04) begin
            mismatched++;
            $display("FAIL wrap_seq[3] got=%h want=04", got_pc.size() >= 4 ? got_pc[3] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h20;
        step();
        bus.redirect_pc = 8'h60;
        step();
        bus.redirect_valid = 1'b0;
        compared += 2;
        if (bus.imem_addr !== 8'h60) begin mismatched++; $display("FAIL b2b_addr got=%h want=60", bus.imem_addr); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_r1 got=%b want=0", bus.out_valid); end
        step();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_r2 got=%b want=0", bus.out_valid); end
        step();
        compared += 2;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_r3_valid got=%b want=1", bus.out_valid); end
        if (bus.out_pc !== 8'h60) begin mismatched++; $display("FAIL b2b_r3_pc got=%h want=60", bus.out_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) step();
        compared++;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL mid_pre_valid got=%b want=1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_async_valid got=%b want=0", bus.out_valid); end
        if (bus.imem_addr !== 8'h00) begin mismatched++; $display("FAIL mid_async_addr got=%h want=00", bus.imem_addr); end
`ifdef FETCH_PERF_EN
        compared += 2;
        if (perf_fetched !== 32'd0) begin mismatched++; $display("FAIL mid_perf_fetched got=%0d want=0", perf_fetched); end
        if (perf_stall !== 32'd0) begin mismatched++; $display("FAIL mid_perf_stall got=%0d want=0", perf_stall); end
`endif
        step();
        rst_n = 1'b1;
        step();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_c1_valid got=%b want=0", bus.out_valid); end
        step();
        compared += 2;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL mid_c2_valid got=%b want=1", bus.out_valid); end
        if (bus.out_pc !== 8'h00) begin mismatched++; $display("FAIL mid_c2_pc got=%h want=00", bus.out_pc); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        compared += 2;
        if (perf_fetched !== 32'd0) begin mismatched++; $display("FAIL perf_c0_fetched got=%0d want=0", perf_fetched); end
        if (perf_stall !== 32'd0) begin mismatched++; $display("FAIL perf_c0_stall got=%0d want=0", perf_stall); end
        repeat (2) step();
        repeat (4) step();
        compared++;
        if (perf_fetched !== 32'd4) begin mismatched++; $display("FAIL perf_fetched got=%0d want=4", perf_fetched); end
        bus.out_ready = 1'b0;
        repeat (3) step();
        compared += 2;
        if (perf_stall !== 32'd3) begin mismatched++; $display("FAIL perf_stall got=%0d want=3", perf_stall); end
        if (perf_fetched !== 32'd4) begin mismatched++; $display("FAIL perf_fetched_held got=%0d want=4", perf_fetched); end
        bus.out_ready = 1'b1;
    endtask
`endif

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_stalled();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
